// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake, and holds
// the word with its jump field and sign-extended immediate until decode accepts it.
// Optional macro PC_FETCH_ALIGN_CHK_EN adds a terminal ERR state for misaligned next PCs.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        ins_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [25:0] d_ins26,
  output logic [31:0] d_ext32,
  output logic [31:0] fetch_cnt,
  output logic        misalign
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned J_W   = 26;
  localparam int unsigned IMM_W = 16;

`ifdef PC_FETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ins_q, ins_d;
  logic [J_W-1:0]    ins26_q, ins26_d;
  logic [XLEN-1:0]   ext32_q, ext32_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              ins_ld;

  // Next-state and next-value logic; register outputs are decoded from the next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ins_ld  = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ins_ld  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ins_ready) begin
          pc_d    = npc;
          cnt_d   = cnt_q + XLEN'(1);
`ifdef PC_FETCH_ALIGN_CHK_EN
          state_d = (npc[1:0] != 2'b00) ? ERR : FETCH;
`else
          state_d = FETCH;
`endif
        end
      end
`ifdef PC_FETCH_ALIGN_CHK_EN
      ERR:     state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase

    ins_d   = ins_ld ? imem_rdata : ins_q;
    ins26_d = ins_ld ? imem_rdata[J_W-1:0] : ins26_q;
    ext32_d = ins_ld ? {{(XLEN-IMM_W){imem_rdata[IMM_W-1]}}, imem_rdata[IMM_W-1:0]} : ext32_q;
    req_d   = (state_d == FETCH);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      ins26_q <= '0;
      ext32_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      ins26_q <= ins26_d;
      ext32_q <= ext32_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_FETCH_ALIGN_CHK_EN
  logic mis_q;

  // Sticky once ERR is entered; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= (state_d == ERR);
  end

  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins       = ins_q;
  assign ins_valid = valid_q;
  assign d_ins26   = ins26_q;
  assign d_ext32   = ext32_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: fetched words are queued at ack time and checked
// by a monitor on each ins_valid rise; control/PC behaviour is checked inline.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic        ins_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        ins_valid;
  logic [25:0] d_ins26;
  logic [31:0] d_ext32;
  logic [31:0] fetch_cnt;
  logic        misalign;

  typedef struct packed {
    logic [31:0] ins;
    logic [25:0] ins26;
    logic [31:0] ext32;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_valid = 1'b0;

  pc_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .npc       (npc),
    .ins_ready (ins_ready),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .ins       (ins),
    .ins_valid (ins_valid),
    .d_ins26   (d_ins26),
    .d_ext32   (d_ext32),
    .fetch_cnt (fetch_cnt),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [25:0] j, input logic [31:0] e,
                      input logic [31:0] p);
    exp_t x;
    x.ins = w; x.ins26 = j; x.ext32 = e; x.pc = p;
    exp_q.push_back(x);
  endtask

  // Monitor: compare the held instruction against the scoreboard when it becomes valid
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ins_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got ins %h expected no instruction", ins);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("mon_ins", ins, x.ins);
        check("mon_ins26", 32'(d_ins26), 32'(x.ins26));
        check("mon_ext32", d_ext32, x.ext32);
        check("mon_pc", pc, x.pc);
      end
    end
    prev_valid <= ins_valid;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; npc = '0; ins_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (3) tick();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_ext32", d_ext32, 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);

    // IDLE for one cycle, then request at RESET_PC
    rst_n = 1'b1;
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, 32'h0000_3000);

    // Ack in the first FETCH cycle, negative immediate
    imem_ack = 1'b1; imem_rdata = 32'h1000_FFFC;
    push(32'h1000_FFFC, 26'h000_FFFC, 32'hFFFF_FFFC, 32'h0000_3000);
    tick();
    imem_ack = 1'b0;
    check("hold_valid", 32'(ins_valid), 32'd1);
    check("hold_req", 32'(imem_req), 32'd0);

    // Stall with ins_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ins", ins, 32'h1000_FFFC);
      check("stall_pc", pc, 32'h0000_3000);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_valid", 32'(ins_valid), 32'd1);
    end

    ins_ready = 1'b1; npc = 32'h0000_3004;
    tick();
    ins_ready = 1'b0;
    check("acc1_pc", pc, 32'h0000_3004);
    check("acc1_cnt", fetch_cnt, 32'd1);
    check("acc1_req", 32'(imem_req), 32'd1);
    check("acc1_valid", 32'(ins_valid), 32'd0);

    // Delayed ack: address held stable, ins_ready ignored outside HOLD
    ins_ready = 1'b1; npc = 32'h0000_5000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_addr", imem_addr, 32'h0000_3004);
      check("wait_req", 32'(imem_req), 32'd1);
    end
    ins_ready = 1'b0;
    check("wait_cnt", fetch_cnt, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hABCD_8001;
    push(32'hABCD_8001, 26'h3CD_8001, 32'hFFFF_8001, 32'h0000_3004);
    tick();

    // Spurious ack in HOLD must be ignored
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("spur_ins", ins, 32'hABCD_8001);
    check("spur_ext32", d_ext32, 32'hFFFF_8001);
    check("spur_valid", 32'(ins_valid), 32'd1);
    check("spur_req", 32'(imem_req), 32'd0);

    ins_ready = 1'b1; npc = 32'h0000_3008;
    tick();
    ins_ready = 1'b0;
    check("acc2_addr", imem_addr, 32'h0000_3008);
    check("acc2_cnt", fetch_cnt, 32'd2);

    // Positive immediate
    imem_ack = 1'b1; imem_rdata = 32'h0C00_7FFF;
    push(32'h0C00_7FFF, 26'h000_7FFF, 32'h0000_7FFF, 32'h0000_3008);
    tick();
    imem_ack = 1'b0;

    // Misaligned next PC
    ins_ready = 1'b1; npc = 32'h0000_3006;
    tick();
    ins_ready = 1'b0;
    check("mis_pc", pc, 32'h0000_3006);
    check("mis_cnt", fetch_cnt, 32'd3);
`ifdef PC_FETCH_ALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      check("err_mis", 32'(misalign), 32'd1);
      check("err_req", 32'(imem_req), 32'd0);
      check("err_valid", 32'(ins_valid), 32'd0);
      tick();
    end
`else
    check("mis_addr", imem_addr, 32'h0000_3006);
    check("mis_flag", 32'(misalign), 32'd0);
    check("mis_req", 32'(imem_req), 32'd1);
`endif

    // Reset during a cycle carrying ack discards the data
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("mrst_pc", pc, 32'h0000_3000);
    check("mrst_valid", 32'(ins_valid), 32'd0);
    check("mrst_cnt", fetch_cnt, 32'd0);
    check("mrst_ins", ins, 32'd0);
    check("mrst_req", 32'(imem_req), 32'd0);
    check("mrst_mis", 32'(misalign), 32'd0);

    // Recovery fetch after reset
    rst_n = 1'b1;
    tick();
    check("rec_addr", imem_addr, 32'h0000_3000);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0C01;
    push(32'h0800_0C01, 26'h000_0C01, 32'h0000_0C01, 32'h0000_3000);
    tick();
    imem_ack = 1'b0;
    tick();
    check("rec_ins", ins, 32'h0800_0C01);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
